// File: rtl/tdm_pkg.sv
// Shared types and limits for the 2:1 TDM receive path.
// Imported by the demultiplexer top and its per-channel deserializer.
package tdm_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    SLOT_CH0 = 1'b0,
    SLOT_CH1 = 1'b1
  } slot_e;

endpackage

// File: rtl/deser_shift.sv
// One channel's serial-to-parallel shift register with shift-enable and clear.
// word_next_o is the value the register takes at the coming edge.
module deser_shift #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] word_next_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] base;

  // Clear and shift may coincide: the new bit then lands in an emptied word.
  always_comb begin
    base   = clr ? '0 : word_q;
    word_d = base;
    if (shift_en) begin
      if (LSB_FIRST) begin
        word_d = {din, base[WIDTH-1:1]};
      end else begin
        word_d = {base[WIDTH-2:0], din};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_next_o = word_d;

endmodule

// File: rtl/tdm_demux2.sv
// Receive side of a 2:1 TDM link: locks on frame sync, splits alternating
// bits into channel 0/1 and presents both words with a one-cycle valid.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             valid,
  output logic             sel,
  output logic             sync_err,
  output state_e           state_dbg
);

  // Handshake: valid is a one-cycle pulse with no back-pressure; q0/q1 hold
  // until the next pulse, so consumers must sample within 2*WIDTH en cycles.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  slot_e            sel_q;
  logic [CW-1:0]    bitcnt_q;
  logic [WIDTH-1:0] q0_q;
  logic [WIDTH-1:0] q1_q;
  logic             valid_q;
  logic             sync_err_q;

  logic             at_frame_start;
  logic             resync;
  logic             restart;
  logic             ch0_shift;
  logic             ch1_shift;
  logic [WIDTH-1:0] ch0_next;
  logic [WIDTH-1:0] ch1_next;

  assign at_frame_start = (sel_q == SLOT_CH0) && (bitcnt_q == '0);
  assign resync  = (state_q == RUN) && en && sync && !at_frame_start;
  assign restart = ((state_q == HUNT) && en && sync) || resync;

  // A resync bit always belongs to channel 0, whichever slot was expected.
  assign ch0_shift = restart || ((state_q == RUN) && en && (sel_q == SLOT_CH0));
  assign ch1_shift = (state_q == RUN) && en && (sel_q == SLOT_CH1) && !resync;

  deser_shift #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_ch0 (
    .clk         (clk),
    .rst         (rst),
    .clr         (restart),
    .shift_en    (ch0_shift),
    .din         (din),
    .word_next_o (ch0_next)
  );

  deser_shift #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_ch1 (
    .clk         (clk),
    .rst         (rst),
    .clr         (restart),
    .shift_en    (ch1_shift),
    .din         (din),
    .word_next_o (ch1_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      sel_q      <= SLOT_CH0;
      bitcnt_q   <= '0;
      q0_q       <= '0;
      q1_q       <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (en && sync) begin
            state_q  <= RUN;
            sel_q    <= SLOT_CH1;
            bitcnt_q <= '0;
          end
        end
        RUN: begin
          if (en) begin
            if (resync) begin
              sync_err_q <= 1'b1;
              sel_q      <= SLOT_CH1;
              bitcnt_q   <= '0;
            end else if (sel_q == SLOT_CH0) begin
              sel_q <= SLOT_CH1;
            end else if (bitcnt_q == LAST) begin
              sel_q    <= SLOT_CH0;
              bitcnt_q <= '0;
              valid_q  <= 1'b1;
              q0_q     <= ch0_next;
              q1_q     <= ch1_next;
            end else begin
              sel_q    <= SLOT_CH0;
              bitcnt_q <= bitcnt_q + CW'(1);
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign q0        = q0_q;
  assign q1        = q1_q;
  assign valid     = valid_q;
  assign sel       = sel_q;
  assign sync_err  = sync_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Bench for tdm_demux2: a 4-bit LSB-first and an 8-bit MSB-first instance
// checked each cycle against a bit-position model of the frame format.
module tb_tdm_demux2;
  import tdm_pkg::*;

  logic clk;
  logic rst_a, en_a, sync_a, din_a;
  logic rst_b, en_b, sync_b, din_b;
  logic [3:0] q0_a, q1_a;
  logic [7:0] q0_b, q1_b;
  logic valid_a, sel_a, sync_err_a;
  logic valid_b, sel_b, sync_err_b;
  state_e state_a, state_b;

  int n_cmp = 0;
  int n_mis = 0;

  // model state, index 0 = instance a (W=4, LSB first), 1 = instance b (W=8, MSB first)
  bit          m_locked[2];
  int          m_p[2];
  logic [31:0] m_w0[2], m_w1[2], m_q0[2], m_q1[2];
  bit          m_valid[2], m_err[2];

  tdm_demux2 #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .en(en_a), .sync(sync_a),
    .q0(q0_a), .q1(q1_a), .valid(valid_a), .sel(sel_a),
    .sync_err(sync_err_a), .state_dbg(state_a)
  );

  tdm_demux2 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .en(en_b), .sync(sync_b),
    .q0(q0_b), .q1(q1_b), .valid(valid_b), .sel(sel_b),
    .sync_err(sync_err_b), .state_dbg(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, elapsed %0t, required below 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  task automatic model_reset(input int d);
    m_locked[d] = 1'b0;
    m_p[d]      = 0;
    m_w0[d]     = '0;
    m_w1[d]     = '0;
    m_q0[d]     = '0;
    m_q1[d]     = '0;
    m_valid[d]  = 1'b0;
    m_err[d]    = 1'b0;
  endtask

  // A frame is 2*w bits numbered p = 0..2w-1; even p -> ch0, odd p -> ch1,
  // and the k-th bit of a channel is word bit k (LSB first) or w-1-k.
  task automatic model_step(input int d, input bit e, input bit s, input bit b);
    int w, idx, pos;
    w = width_of(d);
    m_valid[d] = 1'b0;
    m_err[d]   = 1'b0;
    if (!e) return;
    if (!m_locked[d]) begin
      if (!s) return;
      m_locked[d] = 1'b1;
      m_p[d] = 0;
    end else if (s && m_p[d] != 0) begin
      m_err[d] = 1'b1;
      m_p[d] = 0;
    end
    idx = m_p[d] / 2;
    pos = (d == 0) ? idx : (w - 1 - idx);
    if (m_p[d] % 2 == 0) m_w0[d][pos] = b;
    else                 m_w1[d][pos] = b;
    m_p[d]++;
    if (m_p[d] == 2 * w) begin
      m_q0[d]    = m_w0[d];
      m_q1[d]    = m_w1[d];
      m_valid[d] = 1'b1;
      m_p[d]     = 0;
    end
  endtask

  task automatic check_outputs(input int d);
    logic [31:0] exp_sel;
    exp_sel = m_locked[d] ? 32'(m_p[d] % 2) : 32'd0;
    if (d == 0) begin
      check_eq("a_valid", {31'd0, valid_a}, {31'd0, m_valid[0]});
      check_eq("a_sync_err", {31'd0, sync_err_a}, {31'd0, m_err[0]});
      check_eq("a_sel", {31'd0, sel_a}, exp_sel);
      check_eq("a_q0", {28'd0, q0_a}, m_q0[0]);
      check_eq("a_q1", {28'd0, q1_a}, m_q1[0]);
      check_eq("a_state", {31'd0, state_a}, {31'd0, m_locked[0]});
    end else begin
      check_eq("b_valid", {31'd0, valid_b}, {31'd0, m_valid[1]});
      check_eq("b_sync_err", {31'd0, sync_err_b}, {31'd0, m_err[1]});
      check_eq("b_sel", {31'd0, sel_b}, exp_sel);
      check_eq("b_q0", {24'd0, q0_b}, m_q0[1]);
      check_eq("b_q1", {24'd0, q1_b}, m_q1[1]);
      check_eq("b_state", {31'd0, state_b}, {31'd0, m_locked[1]});
    end
  endtask

  // One clock on instance d; the other instance sits idle with en low.
  task automatic cycle(input int d, input bit r, input bit e, input bit s, input bit b);
    int o;
    o = 1 - d;
    if (d == 0) begin
      rst_a = r; en_a = e; sync_a = s; din_a = b;
      rst_b = 1'b0; en_b = 1'b0; sync_b = $urandom_range(0, 1); din_b = $urandom_range(0, 1);
    end else begin
      rst_b = r; en_b = e; sync_b = s; din_b = b;
      rst_a = 1'b0; en_a = 1'b0; sync_a = $urandom_range(0, 1); din_a = $urandom_range(0, 1);
    end
    @(posedge clk);
    if (r) model_reset(d);
    else   model_step(d, e, s, b);
    model_step(o, 1'b0, 1'b0, 1'b0);
    #1;
    check_outputs(d);
    check_outputs(o);
  endtask

  task automatic reset_both();
    rst_a = 1'b1; en_a = 1'b1; sync_a = 1'b1; din_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1; sync_b = 1'b1; din_b = 1'b1;
    @(posedge clk);
    model_reset(0);
    model_reset(1);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic send_frame(input int d, input logic [31:0] c0, input logic [31:0] c1,
                            input bit sync_first, input bit gaps);
    int w, pos;
    w = width_of(d);
    for (int i = 0; i < w; i++) begin
      pos = (d == 0) ? i : (w - 1 - i);
      cycle(d, 1'b0, 1'b1, sync_first && (i == 0), c0[pos]);
      if (gaps) cycle(d, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(d, 1'b0, 1'b1, 1'b0, c1[pos]);
      if (gaps) cycle(d, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] basic_bits;
    logic [31:0] r0, r1;
    int err_seen, valid_seen;
    basic_bits = 8'b0110_0110;  // sent MSB of this constant first: 0,1,1,0,0,1,1,0

    reset_both();
    reset_both();

    // basic synced frame
    for (int i = 0; i < 8; i++) cycle(0, 1'b0, 1'b1, i == 0, basic_bits[7 - i]);
    check_eq("t1_valid", {31'd0, valid_a}, 32'd1);
    check_eq("t1_q0", {28'd0, q0_a}, 32'hA);
    check_eq("t1_q1", {28'd0, q1_a}, 32'h5);

    // free-run with en gaps
    send_frame(0, 32'h3, 32'hC, 1'b0, 1'b1);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_q0", {28'd0, q0_a}, 32'h3);
    check_eq("t2_q1", {28'd0, q1_a}, 32'hC);

    // misplaced sync on the 5th bit of a frame, then a full frame from there
    for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 1));
    err_seen = 0;
    valid_seen = 0;
    r0 = $urandom_range(0, 15);
    r1 = $urandom_range(0, 15);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1'b0, 1'b1, i == 0, r0[i]);
      err_seen += int'(sync_err_a);
      valid_seen += int'(valid_a);
      cycle(0, 1'b0, 1'b1, 1'b0, r1[i]);
      err_seen += int'(sync_err_a);
      if (i < 3) valid_seen += int'(valid_a);
    end
    check_eq("t3_err_count", 32'(err_seen), 32'd1);
    check_eq("t3_no_partial_valid", 32'(valid_seen), 32'd0);
    check_eq("t3_valid", {31'd0, valid_a}, 32'd1);
    check_eq("t3_q0", {28'd0, q0_a}, r0);
    check_eq("t3_q1", {28'd0, q1_a}, r1);

    // hunt: no sync after reset
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 1));
    check_eq("t4_q0", {28'd0, q0_a}, 32'h0);
    check_eq("t4_sel", {31'd0, sel_a}, 32'd0);

    // reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) cycle(0, 1'b0, 1'b1, i == 0, $urandom_range(0, 1));
    cycle(0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("t5_state", {31'd0, state_a}, {31'd0, HUNT});
    send_frame(0, 32'h9, 32'h6, 1'b1, 1'b0);
    check_eq("t5_q0", {28'd0, q0_a}, 32'h9);
    check_eq("t5_q1", {28'd0, q1_a}, 32'h6);

    // MSB-first 8-bit instance
    send_frame(1, 32'hB4, 32'h1E, 1'b1, 1'b0);
    check_eq("t6_valid", {31'd0, valid_b}, 32'd1);
    check_eq("t6_q0", {24'd0, q0_b}, 32'hB4);
    check_eq("t6_q1", {24'd0, q1_b}, 32'h1E);

    // random traffic on both instances
    for (int n = 0; n < 600; n++) begin
      int d;
      d = $urandom_range(0, 1);
      cycle(d, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1));
    end
    for (int k = 0; k < 3; k++) begin
      send_frame(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, k[0]);
      send_frame(1, $urandom_range(0, 255), $urandom_range(0, 255), k == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Receiving end of a 2:1 time-division link. The transmitter's 2->1 mux alternates its select every bit slot, interleaving channel 0 and channel 1 onto one serial line.
- This block locks onto frame sync, steers each serial bit back to its channel, and deserializes each channel into a WIDTH-bit word.
- It emits both words together with a one-cycle valid pulse.
- It sits between the serial link and the parallel consumers of channel 0 and channel 1.

Parameters:
- WIDTH, 8, bits per channel word. A frame is 2*WIDTH serial bits. Legal range is 2..32.
- LSB_FIRST, 1, 1 = the first received bit of a channel is bit 0; 0 = it is bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial interleaved data bit
- en  input  1  bit strobe; din/sync are sampled only on cycles with en=1
- sync  input  1  frame marker; qualified by en; marks channel-0 bit of slot 0 of a frame
- q0  output  WIDTH  last complete channel-0 word
- q1  output  WIDTH  last complete channel-1 word
- valid  output  1  one-cycle pulse: q0/q1 were updated this cycle
- sel  output  1  slot expected for the next en bit (0 = ch0, 1 = ch1); mirrors the transmitter's mux select
- sync_err  output  1  one-cycle pulse: sync seen at a non-frame-start position

Behaviour:
- Reset (rst=1 at edge) puts the block in this state:
  - q0 = q1 = 0; valid = 0; sync_err = 0; sel = 0; state = HUNT.
  - Bit counter = 0; shift registers = 0.
  - Reset wins over every other input on the same edge. A reset mid-frame discards all partial bits.
- States:
  - HUNT: din is ignored. On en & sync, din is captured as ch0 bit slot 0, bitcnt = 0, sel -> 1, go to RUN.
  - RUN: on each en cycle, din is shifted into the channel register selected by sel, then sel toggles.
    - After a ch1 capture, bitcnt increments.
    - Frame complete = ch1 capture with bitcnt == WIDTH-1. On that edge:
      - q0/q1 load the completed words, including the bit just received.
      - valid = 1 for exactly the next cycle.
      - bitcnt = 0, sel = 0.
- Latency: valid and the new q0/q1 appear one clock after the edge that samples the final ch1 bit. q0/q1 hold their value until the next valid.
- en = 0: no state, counter, sel or shift-register change. valid and sync_err still drop after one cycle.
- Sync in RUN:
  - en & sync at a frame start (sel = 0, bitcnt = 0): normal; no error.
  - en & sync anywhere else: sync_err pulses one cycle and the partial frame is discarded. That bit is taken as ch0 slot 0 of a new frame (resync), bitcnt = 0, sel -> 1. There is no valid for the discarded frame.
  - Absence of sync at later frame starts is legal; the block free-runs on its counter once locked.
- Bit order:
  - LSB_FIRST = 1: the shift register shifts right and din enters the MSB, so after WIDTH bits the first bit is at bit 0.
  - LSB_FIRST = 0: it shifts left and din enters the LSB.
- No overrun handling: consumers must take q0/q1 within 2*WIDTH en cycles.
- In HUNT, sel = 0.

Decomposition:
- Package tdm_pkg holds:
  - The state enum (HUNT, RUN).
  - The slot type (SLOT_CH0 = 0, SLOT_CH1 = 1).
  - Constant MAX_WIDTH = 32.
- One sub-module, deser_shift: WIDTH/LSB_FIRST-parameterised shift register with shift-enable and clear. It is instantiated once per channel.
- The FSM, bit counter, sel and output registers live in tdm_demux2.

Test Plan:
1. Basic frame. WIDTH = 4, LSB_FIRST = 1, en = 1 continuously. Send din = 0,1,1,0,0,1,1,0 with sync on the first bit. Expected: valid pulses one cycle after the 8th bit, q0 = 4'hA, q1 = 4'h5, and sel toggles 1,0,1,0,... during the frame.
2. Free-run, en gaps. Send a second frame without sync, with en low every other cycle, sending ch0 = 4'h3, ch1 = 4'hC. Expected: a second valid with q0 = 4'h3, q1 = 4'hC; the state holds during en = 0 gaps.
3. Misplaced sync. Assert sync on bit 5 of a frame. Expected: sync_err pulses once, there is no valid for the partial frame, and the next 8 bits (starting at bit 5) produce a valid with the correct words.
4. Hunt. Send 6 random bits with no sync after reset. Expected: no valid, sel stays 0, q0 = q1 = 0.
5. Reset mid-frame. Assert rst after 3 bits. Expected: all outputs 0, state HUNT, and the subsequent synced frame 4'h9/4'h6 decodes correctly.
6. MSB-first. LSB_FIRST = 0, WIDTH = 8, ch0 = 8'hB4, ch1 = 8'h1E. Expected: valid with q0 = 8'hB4, q1 = 8'h1E after 16 en bits.
